// File: rtl/arbitro_escritura_registros_pkg.sv
// Shared definitions for the register-file write-back arbiter.
//   NUM_REGS / ADDR_W / DATA_W : register file geometry (NUM_REGS = 2**ADDR_W)
//   REG_ZERO                   : hard-wired register, never written or reserved
//   gnt_e                      : grant encoding, also the round-robin pointer value
package arbitro_escritura_registros_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    localparam int REG_ZERO = 0;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } gnt_e;

    // Round-robin step: after serving one requester, prefer the other.
    function automatic gnt_e otro_solicitante(input gnt_e g);
        return (g == GNT_ALU) ? GNT_MEM : GNT_ALU;
    endfunction

endpackage

// File: rtl/arbitro_escritura_registros_marcador.sv
// marcador_registros: busy scoreboard of destination registers with an
// outstanding write.
//   clk, rst_n          : clock, asynchronous active-low reset
//   set_en, set_addr    : reserve a register (issue stage)
//   clr_en, clr_addr    : release a register (write-back accepted)
//   q1_addr, q2_addr    : lookup addresses
//   busy1, busy2        : combinational busy bits for q1_addr / q2_addr
module marcador_registros
    import arbitro_escritura_registros_pkg::*;
#(
    parameter int NUM_REGS = arbitro_escritura_registros_pkg::NUM_REGS,
    parameter int ADDR_W   = arbitro_escritura_registros_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] q1_addr,
    input  logic [ADDR_W-1:0] q2_addr,
    output logic              busy1,
    output logic              busy2
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // NOTE: busy_d gets its full value before any conditional update, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        // Applied after the clear: a reservation made on the same edge as the
        // release belongs to a newer instruction and must survive.
        if (set_en && (set_addr != ADDR_W'(REG_ZERO))) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    // NOTE: this is a flag vector, not a storage array: every bit must start
    // clear, so the whole vector is reset (unlike a data RAM).
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy1 = busy_q[q1_addr];
    assign busy2 = busy_q[q2_addr];

endmodule

// File: rtl/arbitro_escritura_registros.sv
// arbitro_escritura_registros: shares the register-file write port between
// the ALU write-back (req0) and the load write-back (req1).
//   clk, rst_n                  : clock, asynchronous active-low reset
//   req0_valid/addr/data/ready  : ALU write-back handshake
//   req1_valid/addr/data/ready  : load write-back handshake
//   res_valid, res_addr         : issue-stage destination reservation
//   q1_addr, q2_addr, hz1, hz2  : issue-stage hazard lookups (busy bits)
//   AW, DW, EnW                 : registered register-file write port
module arbitro_escritura_registros
    import arbitro_escritura_registros_pkg::*;
#(
    parameter int NUM_REGS = arbitro_escritura_registros_pkg::NUM_REGS,
    parameter int ADDR_W   = arbitro_escritura_registros_pkg::ADDR_W,
    parameter int DATA_W   = arbitro_escritura_registros_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              res_valid,
    input  logic [ADDR_W-1:0] res_addr,
    input  logic [ADDR_W-1:0] q1_addr,
    input  logic [ADDR_W-1:0] q2_addr,
    output logic              hz1,
    output logic              hz2,
    output logic [ADDR_W-1:0] AW,
    output logic [DATA_W-1:0] DW,
    output logic              EnW
);

    gnt_e              ptr_q;     // requester preferred on contention
    gnt_e              gnt;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Grant logic. Readies are held low during reset so no transfer can be
    // observed by a requester while the block is being cleared.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst_n) begin
            if (req0_valid && (!req1_valid || (ptr_q == GNT_ALU))) begin
                req0_ready = 1'b1;
            end else if (req1_valid) begin
                req1_ready = 1'b1;
            end
        end
    end

    assign xfer     = req0_ready | req1_ready;
    assign gnt      = req1_ready ? GNT_MEM : GNT_ALU;
    assign sel_addr = req1_ready ? req1_addr : req0_addr;
    assign sel_data = req1_ready ? req1_data : req0_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= GNT_ALU;
        end else if (xfer) begin
            ptr_q <= otro_solicitante(gnt);
        end
    end

    // Write port. Writes to register zero are accepted upstream but never
    // reach the register file; AW/DW keep their last value when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            EnW <= 1'b0;
            AW  <= '0;
            DW  <= '0;
        end else if (xfer && (sel_addr != ADDR_W'(REG_ZERO))) begin
            EnW <= 1'b1;
            AW  <= sel_addr;
            DW  <= sel_data;
        end else begin
            EnW <= 1'b0;
        end
    end

    // The release happens on the accept edge, so busy is already clear in the
    // EnW cycle; the register file forwards the new value to same-cycle reads.
    marcador_registros #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_marcador (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (res_valid),
        .set_addr (res_addr),
        .clr_en   (xfer),
        .clr_addr (sel_addr),
        .q1_addr  (q1_addr),
        .q2_addr  (q2_addr),
        .busy1    (hz1),
        .busy2    (hz2)
    );

endmodule

// File: tb/tb_arbitro_escritura_registros.sv
// Self-checking bench for arbitro_escritura_registros: a stimulus process
// drives requests and pushes the expected register-file writes into a queue;
// a monitor pops them on the falling edge and compares AW/DW/EnW.
module tb_arbitro_escritura_registros;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        res_valid;
    logic [4:0]  res_addr;
    logic [4:0]  q1_addr;
    logic [4:0]  q2_addr;
    logic        hz1;
    logic        hz2;
    logic [4:0]  AW;
    logic [31:0] DW;
    logic        EnW;

    arbitro_escritura_registros dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_addr   (res_addr),
        .q1_addr    (q1_addr),
        .q2_addr    (q2_addr),
        .hz1        (hz1),
        .hz2        (hz2),
        .AW         (AW),
        .DW         (DW),
        .EnW        (EnW)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          due;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    // Reference model state: which registers are reserved, and whether req0
    // wins the next contention (true after reset and after a req1 grant).
    logic [31:0] busy_m   = '0;
    bit          prefer0  = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic drive(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                         input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                         input bit rv, input logic [4:0] ra,
                         input logic [4:0] qa, input logic [4:0] qb,
                         output bit g0, output bit g1);
        bit e0;
        bit e1;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        res_valid  = rv; res_addr  = ra;
        q1_addr    = qa; q2_addr   = qb;
        #2;
        e0 = v0 && (!v1 || prefer0);
        e1 = v1 && !e0;
        check("req0_ready", 32'(req0_ready), 32'(e0));
        check("req1_ready", 32'(req1_ready), 32'(e1));
        check("one_ready",  32'(req0_ready & req1_ready), 32'(0));
        check("hz1", 32'(hz1), 32'(busy_m[qa]));
        check("hz2", 32'(hz2), 32'(busy_m[qb]));
        if (e0) begin
            if (a0 != 5'd0) exp_q.push_back('{addr: a0, data: d0, due: cyc + 1});
            busy_m[a0] = 1'b0;
            prefer0 = 1'b0;
        end
        if (e1) begin
            if (a1 != 5'd0) exp_q.push_back('{addr: a1, data: d1, due: cyc + 1});
            busy_m[a1] = 1'b0;
            prefer0 = 1'b1;
        end
        if (rv) busy_m[ra] = 1'b1;
        busy_m[0] = 1'b0;
        g0 = e0;
        g1 = e1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] qa, input logic [4:0] qb);
        bit g0;
        bit g1;
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, qa, qb, g0, g1);
    endtask

    // Monitor: every active cycle either the queue head is due (write
    // expected) or the write enable must be low.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL missed_write: got none expected AW=%0d DW=%h", exp_q[0].addr, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    check("EnW", 32'(EnW), 32'(1));
                    check("AW",  32'(AW),  32'(exp_q[0].addr));
                    check("DW",  DW,       exp_q[0].data);
                    void'(exp_q.pop_front());
                end else begin
                    check("EnW_idle", 32'(EnW), 32'(0));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit          g0;
        bit          g1;
        bit          p0;
        bit          p1;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        int          grants;

        // Reset with both contention requests already presented.
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h22;
        res_valid = 1'b0; res_addr = 5'd0; q1_addr = 5'd0; q2_addr = 5'd0;
        #3;
        check("rst_EnW", 32'(EnW), 32'(0));
        check("rst_AW",  32'(AW),  32'(0));
        check("rst_DW",  DW,       32'(0));
        check("rst_req0_ready", 32'(req0_ready), 32'(0));
        check("rst_req1_ready", 32'(req1_ready), 32'(0));
        check("rst_hz1", 32'(hz1), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Contention: req0 first, req1 next cycle, then a fresh pair starts
        // with req0 again.
        drive(1, 5'd4, 32'h11, 1, 5'd7, 32'h22, 0, 5'd0, 5'd4, 5'd7, g0, g1);
        check("cont_first_is_req0", 32'(g0), 32'(1));
        drive(0, 5'd0, 32'h0,  1, 5'd7, 32'h22, 0, 5'd0, 5'd4, 5'd7, g0, g1);
        drive(1, 5'd10, 32'h33, 1, 5'd11, 32'h44, 0, 5'd0, 5'd10, 5'd11, g0, g1);
        check("cont_pair2_req0", 32'(g0), 32'(1));
        drive(0, 5'd0, 32'h0, 1, 5'd11, 32'h44, 0, 5'd0, 5'd10, 5'd11, g0, g1);
        idle(5'd0, 5'd0);

        // Single request.
        drive(1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd0, g0, g1);
        idle(5'd3, 5'd0);
        idle(5'd3, 5'd0);

        // Scoreboard hazard on register 9.
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd9, g0, g1);
        idle(5'd9, 5'd1);
        idle(5'd9, 5'd9);
        drive(0, 5'd0, 32'h0, 1, 5'd9, 32'h99, 0, 5'd0, 5'd9, 5'd9, g0, g1);
        idle(5'd9, 5'd9);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd0, g0, g1);
        // Reservation and release on the same edge: reservation survives.
        drive(0, 5'd0, 32'h0, 1, 5'd9, 32'h9A, 1, 5'd9, 5'd9, 5'd0, g0, g1);
        idle(5'd9, 5'd9);
        drive(1, 5'd9, 32'h9B, 0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd0, g0, g1);
        idle(5'd9, 5'd0);

        // Register zero: accepted, never written, never reserved.
        drive(0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 5'd0, 5'd0, g0, g1);
        check("zero_accepted", 32'(g1), 32'(1));
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);

        // Random stream: each requester holds its request until granted.
        p0 = 0; p1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        grants = 0;
        for (int c = 0; c < 200 && grants < 20; c++) begin
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0 = 1; a0 = 5'($urandom_range(0, 31)); d0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 3) != 0) begin
                p1 = 1; a1 = 5'($urandom_range(0, 31)); d1 = $urandom;
            end
            drive(p0, a0, d0, p1, a1, d1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), g0, g1);
            if (g0) begin p0 = 0; grants++; end
            if (g1) begin p1 = 0; grants++; end
        end
        check("stream_grants", 32'(grants), 32'(20));
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);

        // Reset mid-operation with a write in flight and register 5 busy.
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd5, 5'd5, 5'd5, g0, g1);
        drive(1, 5'd3, 32'hCAFEF00D, 0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd5, g0, g1);
        check("pre_rst_EnW", 32'(EnW), 32'(1));
        check("pre_rst_hz1", 32'(hz1), 32'(busy_m[5]));
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_EnW", 32'(EnW), 32'(0));
        check("mid_rst_AW",  32'(AW),  32'(0));
        check("mid_rst_DW",  DW,       32'(0));
        check("mid_rst_hz1", 32'(hz1), 32'(0));
        check("mid_rst_req0_ready", 32'(req0_ready), 32'(0));
        exp_q.delete();
        busy_m  = '0;
        prefer0 = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5'd5, 5'd5);
        drive(1, 5'd6, 32'h12345678, 1, 5'd8, 32'h87654321, 0, 5'd0, 5'd5, 5'd6, g0, g1);
        check("post_rst_req0_pref", 32'(g0), 32'(1));
        idle(5'd5, 5'd0);
        idle(5'd0, 5'd0);

        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arbitro_escritura_registros.md
Name: arbitro_escritura_registros

Overview:
- Shares the single write port of the 32x32 register file between two write-back requesters: ALU result (req0) and memory load (req1).
- Arbitrates between them round-robin and drives a registered write port (AW/DW/EnW).
- Keeps a busy scoreboard of destination registers with outstanding writes, so the issue stage can detect read-after-write hazards on its two read addresses.
- Sits between the execute/memory stages and the register file.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hard-wired and never written.
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W.
- DATA_W, 32, write data width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  ALU write-back request
- req0_addr  in  ADDR_W  ALU destination register
- req0_data  in  DATA_W  ALU result
- req0_ready  out  1  ALU request accepted this cycle
- req1_valid  in  1  load write-back request
- req1_addr  in  ADDR_W  load destination register
- req1_data  in  DATA_W  load data
- req1_ready  out  1  load request accepted this cycle
- res_valid  in  1  issue stage reserves a destination register
- res_addr  in  ADDR_W  register being reserved
- q1_addr  in  ADDR_W  issue-stage read address 1
- q2_addr  in  ADDR_W  issue-stage read address 2
- hz1  out  1  busy[q1_addr]
- hz2  out  1  busy[q2_addr]
- AW  out  ADDR_W  register-file write address
- DW  out  DATA_W  register-file write data
- EnW  out  1  register-file write enable

Behaviour:
- Reset (async, rst_n=0):
  - EnW=0, AW=0, DW=0.
  - All busy bits = 0.
  - Round-robin pointer = req0-preferred.
  - req*_ready=0 while in reset.
- Handshake:
  - A transfer occurs on a rising edge with valid&&ready.
  - The requester holds valid, addr and data stable until ready.
  - readyN is combinational from the valids and the pointer. At most one ready is high per cycle.
  - Only one valid: that requester is granted.
  - Both valid: the grant goes to the requester the pointer prefers.
  - After any grant, the pointer prefers the other requester. Worst-case wait is 1 grant.
- Write port:
  - On the edge of a transfer to a nonzero address: EnW<=1, AW<=addr, DW<=data. Latency is 1 cycle from accept to EnW.
  - With no transfer: EnW<=0; AW and DW hold their last values.
  - Back-to-back transfers give EnW high on consecutive cycles. Throughput is 1 write per cycle.
- Address 0: the request is accepted (ready=1, pointer advances) but EnW<=0. The write is dropped.
- Scoreboard:
  - busy[res_addr] is set on an edge with res_valid and res_addr!=0.
  - busy[addr] is cleared on the edge of the transfer for addr. During the resulting EnW cycle, busy is already 0; the register file writes combinationally, so the same-cycle read returns new data.
  - Same edge sets and clears the same register: set wins (a newer reservation is outstanding).
  - busy[0] is always 0.
- hz1 and hz2 are combinational lookups of the current busy bits.
- Reset mid-operation: any pending EnW is cancelled immediately and all reservations are discarded. Requesters must re-present.

Decomposition:
- Shared package holds:
  - Constants NUM_REGS, ADDR_W, DATA_W.
  - Localparam REG_ZERO=0.
  - Grant encoding GNT_ALU=0 and GNT_MEM=1 (also used for the round-robin pointer).
- One natural sub-module, marcador_registros: the NUM_REGS-bit busy vector with set/clear/query logic and set-wins priority.
- Arbiter and write-port register stay in the top level.

Test Plan:
- Reset: assert rst_n=0 mid-run with EnW=1 and busy[5]=1 -> EnW=0, AW=0, DW=0, hz1=0 for q1_addr=5, immediately and asynchronously.
- Single request: req0 valid, addr=3, data=0xDEADBEEF -> req0_ready=1 same cycle; next cycle EnW=1, AW=3, DW=0xDEADBEEF; following cycle EnW=0.
- Contention:
  - Stimulus: req0 (addr 4, 0x11) and req1 (addr 7, 0x22) both held valid from reset.
  - Response: grant order req0 then req1 on consecutive cycles; EnW high two cycles with AW=4 then 7.
  - Follow-on: new simultaneous pair -> req0 granted first again, since the pointer alternates after the req1 grant.
- Scoreboard hazard:
  - Stimulus: res_valid, res_addr=9; then q1_addr=9 -> hz1=1 until req1 writes addr 9.
  - Response: hz1=0 in the EnW cycle with AW=9.
  - Follow-on: simultaneous res_addr=9 and transfer to 9 -> hz1 stays 1.
- Register zero: req1 addr=0, data=0xFFFFFFFF -> req1_ready=1, EnW stays 0; res_addr=0 -> hz1 for q1_addr=0 stays 0.
- Stream: 20 random alternating requests -> every accepted nonzero write appears exactly once on AW/DW, in accept order; no cycle has both readies high.
